cdb_arbiter: RTL and testbench

Common Data Bus (CDB) writeback arbiter for the out-of-order core. It collects completed results from the ALU, MUL and LSU functional units through per-unit completion FIFOs. Each cycle it grants at most one completion in round-robin order and broadcasts it as `{cdb_en_o, cdb_tag_o, cdb_data_o}`. Reservation-station entries, the register file and the ROB consume this broadcast for tag wakeup and result writeback.

---
 rtl/cdb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common Data Bus writeback arbiter. Completed results from the ALU, MUL
// and LSU are buffered in small per-unit completion FIFOs. Each cycle at
// most one buffered completion is granted in round-robin order and
// broadcast on the registered CDB outputs for tag wakeup and writeback.
//
// Parameters:
//   FIFO_DEPTH  entries per completion FIFO (power of 2, >= 2)
//   TAG_W       physical destination tag width
//   DATA_W      result width
//
// Ports:
//   clk_i                  clock, rising edge
//   reset_i                asynchronous active-low reset
//   flush_i                synchronous flush, drops all buffered completions
//   <unit>_valid_i         completion valid from the unit (alu/mul/lsu)
//   <unit>_tag_i           destination tag of the completion
//   <unit>_data_i          result value of the completion
//   <unit>_ready_o         that unit's FIFO can accept a completion
//   cdb_en_o               broadcast valid, one cycle per granted completion
//   cdb_tag_o              broadcast tag
//   cdb_data_o             broadcast result
//   cdb_src_o              broadcast source: 0 = ALU, 1 = MUL, 2 = LSU
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cdb_fifo
//
// Single completion FIFO with read pointer, write pointer and occupancy
// count. Storage is deliberately left out of reset; only the bookkeeping
// is cleared, so stale storage is never visible.
//
// Ports:
//   clk_i, reset_i  clock and asynchronous active-low reset
//   flush           drop all entries (wins over push and pop)
//   push            request to enqueue wr_entry (taken only when ready)
//   wr_entry        entry to enqueue
//   pop             dequeue the head entry (caller pops only when nonempty)
//   ready           FIFO is not full
//   nonempty        FIFO holds at least one entry
//   head            entry at the read pointer
// ---------------------------------------------------------------------------
module cdb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_entry,
    input  logic             pop,
    output logic             ready,
    output logic             nonempty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;

    // Ready depends on the registered count only; a full FIFO stays not-ready
    // even when it is being popped in the same cycle.
    assign ready    = (count != CNT_W'(DEPTH));
    assign nonempty = (count != '0);
    assign do_push  = push & ready;
    assign head     = mem[rd_ptr];

    // Pointer and count bookkeeping. DEPTH is a power of two, so the
    // pointers wrap naturally by overflowing their width.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage, written on an accepted push outside a flush.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 5,
    parameter int DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              alu_valid_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              mul_valid_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_data_i,
    input  logic              lsu_valid_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              alu_ready_o,
    output logic              mul_ready_o,
    output logic              lsu_ready_o,
    output logic              cdb_en_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [1:0]        cdb_src_o
);

    localparam int ENTRY_W = TAG_W + DATA_W;

    logic [2:0]         fifo_nonempty;
    logic [2:0]         grant_oh;
    logic [ENTRY_W-1:0] alu_head;
    logic [ENTRY_W-1:0] mul_head;
    logic [ENTRY_W-1:0] lsu_head;

    logic [1:0]         rr_ptr;
    logic [1:0]         rr_next;
    logic [1:0]         cand0;
    logic [1:0]         cand1;
    logic [1:0]         cand2;
    logic               grant_valid;
    logic [1:0]         grant_src;
    logic [ENTRY_W-1:0] grant_entry;

    cdb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_alu_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .flush    (flush_i),
        .push     (alu_valid_i),
        .wr_entry ({alu_tag_i, alu_data_i}),
        .pop      (grant_oh[0]),
        .ready    (alu_ready_o),
        .nonempty (fifo_nonempty[0]),
        .head     (alu_head)
    );

    cdb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mul_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .flush    (flush_i),
        .push     (mul_valid_i),
        .wr_entry ({mul_tag_i, mul_data_i}),
        .pop      (grant_oh[1]),
        .ready    (mul_ready_o),
        .nonempty (fifo_nonempty[1]),
        .head     (mul_head)
    );

    cdb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_lsu_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .flush    (flush_i),
        .push     (lsu_valid_i),
        .wr_entry ({lsu_tag_i, lsu_data_i}),
        .pop      (grant_oh[2]),
        .ready    (lsu_ready_o),
        .nonempty (fifo_nonempty[2]),
        .head     (lsu_head)
    );

    // Round-robin arbitration: the search order is rotated so that it starts
    // at rr_ptr, and the first non-empty source in that order wins. The
    // pointer then moves just past the winner, which bounds any waiting
    // head to two cycles. The pop is suppressed during a flush by the FIFO.
    always_comb begin
        cand0 = 2'd0;
        cand1 = 2'd1;
        cand2 = 2'd2;
        case (rr_ptr)
            2'd1: begin
                cand0 = 2'd1;
                cand1 = 2'd2;
                cand2 = 2'd0;
            end
            2'd2: begin
                cand0 = 2'd2;
                cand1 = 2'd0;
                cand2 = 2'd1;
            end
            default: begin
            end
        endcase

        grant_valid = 1'b1;
        grant_src   = cand0;
        if (fifo_nonempty[cand0]) begin
            grant_src = cand0;
        end else if (fifo_nonempty[cand1]) begin
            grant_src = cand1;
        end else if (fifo_nonempty[cand2]) begin
            grant_src = cand2;
        end else begin
            grant_valid = 1'b0;
        end

        grant_oh    = 3'b000;
        grant_entry = alu_head;
        rr_next     = rr_ptr;
        if (grant_valid) begin
            case (grant_src)
                2'd0: begin
                    grant_oh    = 3'b001;
                    grant_entry = alu_head;
                    rr_next     = 2'd1;
                end
                2'd1: begin
                    grant_oh    = 3'b010;
                    grant_entry = mul_head;
                    rr_next     = 2'd2;
                end
                default: begin
                    grant_oh    = 3'b100;
                    grant_entry = lsu_head;
                    rr_next     = 2'd0;
                end
            endcase
        end
    end

    // Registered CDB broadcast and round-robin pointer. Without a grant only
    // the enable drops; tag, data and source keep their last values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_ptr     <= 2'd0;
            cdb_en_o   <= 1'b0;
            cdb_tag_o  <= '0;
            cdb_data_o <= '0;
            cdb_src_o  <= 2'd0;
        end else if (flush_i) begin
            rr_ptr   <= 2'd0;
            cdb_en_o <= 1'b0;
        end else if (grant_valid) begin
            rr_ptr     <= rr_next;
            cdb_en_o   <= 1'b1;
            cdb_tag_o  <= grant_entry[ENTRY_W-1:DATA_W];
            cdb_data_o <= grant_entry[DATA_W-1:0];
            cdb_src_o  <= grant_src;
        end else begin
            cdb_en_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. Directed scenarios check literal
// expectations; a queue-based reference model (one queue per unit plus a
// round-robin start index) shadows the DUT for the randomized run.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int FIFO_DEPTH = 2;
    localparam int TAG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int ENTRY_W    = TAG_W + DATA_W;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              reset_i;
    logic              flush_i;
    logic              src_valid [3];
    logic [TAG_W-1:0]  src_tag   [3];
    logic [DATA_W-1:0] src_data  [3];

    logic              alu_ready_o;
    logic              mul_ready_o;
    logic              lsu_ready_o;
    logic              cdb_en_o;
    logic [TAG_W-1:0]  cdb_tag_o;
    logic [DATA_W-1:0] cdb_data_o;
    logic [1:0]        cdb_src_o;
    logic [2:0]        rdy;

    assign rdy = {lsu_ready_o, mul_ready_o, alu_ready_o};

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .alu_valid_i (src_valid[0]),
        .alu_tag_i   (src_tag[0]),
        .alu_data_i  (src_data[0]),
        .mul_valid_i (src_valid[1]),
        .mul_tag_i   (src_tag[1]),
        .mul_data_i  (src_data[1]),
        .lsu_valid_i (src_valid[2]),
        .lsu_tag_i   (src_tag[2]),
        .lsu_data_i  (src_data[2]),
        .alu_ready_o (alu_ready_o),
        .mul_ready_o (mul_ready_o),
        .lsu_ready_o (lsu_ready_o),
        .cdb_en_o    (cdb_en_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_src_o   (cdb_src_o)
    );

    // Reference model: each unit's buffered completions as a queue, the
    // round-robin start as an integer, and the expected broadcast registers.
    logic [ENTRY_W-1:0] mq0 [$];
    logic [ENTRY_W-1:0] mq1 [$];
    logic [ENTRY_W-1:0] mq2 [$];
    int                 m_rr   = 0;
    logic               m_en   = 1'b0;
    logic [TAG_W-1:0]   m_tag  = '0;
    logic [DATA_W-1:0]  m_data = '0;
    logic [1:0]         m_src  = 2'd0;

    function automatic int msize(input int k);
        if (k == 0) return mq0.size();
        if (k == 1) return mq1.size();
        return mq2.size();
    endfunction

    function automatic logic [2:0] exp_rdy();
        return {msize(2) != FIFO_DEPTH, msize(1) != FIFO_DEPTH, msize(0) != FIFO_DEPTH};
    endfunction

    task automatic mpop(input int k, output logic [ENTRY_W-1:0] e);
        if (k == 0) e = mq0.pop_front();
        else if (k == 1) e = mq1.pop_front();
        else e = mq2.pop_front();
    endtask

    task automatic mpush(input int k, input logic [ENTRY_W-1:0] e);
        if (k == 0) mq0.push_back(e);
        else if (k == 1) mq1.push_back(e);
        else mq2.push_back(e);
    endtask

    task automatic model_step();
        bit take [3];
        int win;
        logic [ENTRY_W-1:0] e;
        for (int k = 0; k < 3; k++) begin
            take[k] = (src_valid[k] === 1'b1) && (msize(k) != FIFO_DEPTH);
        end
        win = -1;
        for (int i = 0; i < 3; i++) begin
            if (win < 0 && msize((m_rr + i) % 3) > 0) win = (m_rr + i) % 3;
        end
        if (win >= 0) begin
            mpop(win, e);
            m_en   = 1'b1;
            m_tag  = e[ENTRY_W-1:DATA_W];
            m_data = e[DATA_W-1:0];
            m_src  = 2'(win);
            m_rr   = (win + 1) % 3;
        end else begin
            m_en = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            if (take[k]) mpush(k, {src_tag[k], src_data[k]});
        end
    endtask

    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mq0.delete(); mq1.delete(); mq2.delete();
            m_rr = 0; m_en = 1'b0; m_tag = '0; m_data = '0; m_src = 2'd0;
        end else if (flush_i) begin
            mq0.delete(); mq1.delete(); mq2.delete();
            m_rr = 0; m_en = 1'b0;
        end else begin
            model_step();
        end
    end

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            src_valid[k] = 1'b0;
            src_tag[k]   = '0;
            src_data[k]  = '0;
        end
    endtask

    // Pulses flush for one edge and returns at the following negedge.
    task automatic do_flush();
        @(negedge clk_i);
        clear_inputs();
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        flush_i = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got en=%0b tag=%0d data=%h src=%0d, want all 0",
                     cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o);
        end
        checks++;
        if (rdy !== 3'b111) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b, want 111", rdy);
        end
        reset_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            src_valid[k] = 1'b1;
            src_tag[k]   = TAG_W'(11 + k);
            src_data[k]  = DATA_W'(32'h5500_0000 + k);
        end
        @(negedge clk_i);
        for (int k = 0; k < 3; k++) begin
            src_tag[k]  = TAG_W'(14 + k);
            src_data[k] = DATA_W'(32'h6600_0000 + k);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (cdb_en_o !== 1'b1 || cdb_tag_o !== 5'd11 || cdb_src_o !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_prefill: got en=%0b tag=%0d src=%0d, want en=1 tag=11 src=0",
                     cdb_en_o, cdb_tag_o, cdb_src_o);
        end
        #1;
        reset_i = 1'b0;
        #1;
        checks++;
        if ({cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_async: got en=%0b tag=%0d data=%h src=%0d, want all 0",
                     cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o);
        end
        checks++;
        if (rdy !== 3'b111) begin
            failures++;
            $display("[TB] FAIL reset_async_ready: got %b, want 111", rdy);
        end
        clear_inputs();
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if (cdb_en_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_no_stale: cycle %0d got en=%0b tag=%0d, want en=0",
                         i, cdb_en_o, cdb_tag_o);
            end
        end
    endtask

    task automatic test_single();
        src_valid[0] = 1'b1;
        src_tag[0]   = 5'd5;
        src_data[0]  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        clear_inputs();
        checks++;
        if (cdb_en_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_latency: got en=%0b after accept edge, want 0", cdb_en_o);
        end
        @(negedge clk_i);
        checks++;
        if (cdb_en_o !== 1'b1 || cdb_tag_o !== 5'd5 || cdb_data_o !== 32'hDEAD_BEEF || cdb_src_o !== 2'd0) begin
            failures++;
            $display("[TB] FAIL single_bcast: got en=%0b tag=%0d data=%h src=%0d, want 1/5/deadbeef/0",
                     cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o);
        end
        @(negedge clk_i);
        checks++;
        if (cdb_en_o !== 1'b0 || cdb_tag_o !== 5'd5 || cdb_data_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL single_once_hold: got en=%0b tag=%0d data=%h, want 0/5/deadbeef",
                     cdb_en_o, cdb_tag_o, cdb_data_o);
        end
    endtask

    task automatic test_simultaneous();
        do_flush();
        for (int k = 0; k < 3; k++) begin
            src_valid[k] = 1'b1;
            src_tag[k]   = TAG_W'(1 + k);
            src_data[k]  = DATA_W'(32'h1111_0000 + k);
        end
        @(negedge clk_i);
        clear_inputs();
        checks++;
        if (cdb_en_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_latency: got en=%0b, want 0", cdb_en_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (cdb_en_o !== 1'b1 || cdb_tag_o !== TAG_W'(1 + i) || cdb_src_o !== 2'(i)
                || cdb_data_o !== DATA_W'(32'h1111_0000 + i)) begin
                failures++;
                $display("[TB] FAIL simul_order[%0d]: got en=%0b tag=%0d src=%0d data=%h, want 1/%0d/%0d/%h",
                         i, cdb_en_o, cdb_tag_o, cdb_src_o, cdb_data_o, 1 + i, i, 32'h1111_0000 + i);
            end
        end
        @(negedge clk_i);
        checks++;
        if (cdb_en_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_idle: got en=%0b, want 0", cdb_en_o);
        end
    endtask

    task automatic test_backpressure();
        int ai = 0;
        int mi = 0;
        int cyc = 0;
        bit acc_a = 0;
        bit acc_m = 0;
        bit saw_low = 0;
        logic [TAG_W-1:0] rx_a [$];
        logic [TAG_W-1:0] rx_m [$];
        logic [1:0]       rx_s [$];
        do_flush();
        while (cyc < 30 && (rx_a.size() + rx_m.size()) < 10) begin
            if (acc_a) ai++;
            if (acc_m) mi++;
            src_valid[0] = (ai < 5);
            src_tag[0]   = TAG_W'(20 + ai);
            src_data[0]  = DATA_W'(32'hA000_0000 + 20 + ai);
            src_valid[1] = (mi < 5);
            src_tag[1]   = TAG_W'(10 + mi);
            src_data[1]  = DATA_W'(32'hA000_0000 + 10 + mi);
            acc_a = src_valid[0] && rdy[0];
            acc_m = src_valid[1] && rdy[1];
            @(negedge clk_i);
            cyc++;
            if (cdb_en_o === 1'b1) begin
                if (cdb_src_o === 2'd0) rx_a.push_back(cdb_tag_o);
                else rx_m.push_back(cdb_tag_o);
                rx_s.push_back(cdb_src_o);
                checks++;
                if (cdb_data_o !== DATA_W'(32'hA000_0000 + cdb_tag_o)) begin
                    failures++;
                    $display("[TB] FAIL bp_data: tag %0d got data %h, want %h",
                             cdb_tag_o, cdb_data_o, 32'hA000_0000 + cdb_tag_o);
                end
            end
            checks++;
            if (rdy[1] !== (msize(1) != FIFO_DEPTH)) begin
                failures++;
                $display("[TB] FAIL bp_mul_ready: cycle %0d got %0b, want %0b",
                         cyc, rdy[1], msize(1) != FIFO_DEPTH);
            end
            if (rdy[1] === 1'b0) saw_low = 1;
        end
        clear_inputs();
        checks++;
        if (!saw_low) begin
            failures++;
            $display("[TB] FAIL bp_mul_ready_drop: mul_ready_o never seen 0, want a drop when full");
        end
        checks++;
        if (rx_a.size() != 5 || rx_m.size() != 5) begin
            failures++;
            $display("[TB] FAIL bp_count: got alu=%0d mul=%0d broadcasts, want 5 and 5",
                     rx_a.size(), rx_m.size());
        end
        for (int i = 0; i < rx_a.size(); i++) begin
            checks++;
            if (rx_a[i] !== TAG_W'(20 + i)) begin
                failures++;
                $display("[TB] FAIL bp_alu_order[%0d]: got tag %0d, want %0d", i, rx_a[i], 20 + i);
            end
        end
        for (int i = 0; i < rx_m.size(); i++) begin
            checks++;
            if (rx_m[i] !== TAG_W'(10 + i)) begin
                failures++;
                $display("[TB] FAIL bp_mul_order[%0d]: got tag %0d, want %0d", i, rx_m[i], 10 + i);
            end
        end
        for (int i = 0; i < rx_s.size(); i++) begin
            checks++;
            if (rx_s[i] !== 2'(i % 2)) begin
                failures++;
                $display("[TB] FAIL bp_alternate[%0d]: got src %0d, want %0d", i, rx_s[i], i % 2);
            end
        end
    endtask

    task automatic test_flush();
        do_flush();
        src_valid[0] = 1'b1; src_tag[0] = 5'd30; src_data[0] = 32'h3000_0030;
        src_valid[2] = 1'b1; src_tag[2] = 5'd40; src_data[2] = 32'h4000_0040;
        @(negedge clk_i);
        checks++;
        if (cdb_en_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_pre_idle: got en=%0b, want 0", cdb_en_o);
        end
        src_tag[0] = 5'd31; src_data[0] = 32'h3000_0031;
        src_tag[2] = 5'd41; src_data[2] = 32'h4000_0041;
        @(negedge clk_i);
        checks++;
        if (cdb_en_o !== 1'b1 || cdb_tag_o !== 5'd30 || cdb_src_o !== 2'd0) begin
            failures++;
            $display("[TB] FAIL flush_pre_bcast: got en=%0b tag=%0d src=%0d, want 1/30/0",
                     cdb_en_o, cdb_tag_o, cdb_src_o);
        end
        src_valid[0] = 1'b0;
        src_valid[2] = 1'b0;
        src_valid[1] = 1'b1; src_tag[1] = 5'd7; src_data[1] = 32'h0000_0007;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        clear_inputs();
        checks++;
        if (cdb_en_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_en: got en=%0b tag=%0d, want en=0", cdb_en_o, cdb_tag_o);
        end
        checks++;
        if (rdy !== 3'b111) begin
            failures++;
            $display("[TB] FAIL flush_ready: got %b, want 111", rdy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (cdb_en_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL flush_dropped: cycle %0d got en=%0b tag=%0d, want en=0",
                         i, cdb_en_o, cdb_tag_o);
            end
        end
    endtask

    task automatic test_wraparound();
        int ai = 0;
        int li = 0;
        int cyc = 0;
        int acc_cnt = 0;
        bit acc_a = 0;
        bit acc_l = 0;
        bit hold;
        logic [TAG_W-1:0] rx_a [$];
        logic [TAG_W-1:0] rx_l [$];
        do_flush();
        while (cyc < 60 && (rx_a.size() + rx_l.size()) < 10) begin
            if (acc_a) ai++;
            if (acc_l) li++;
            hold = src_valid[0] && !acc_a;
            if (!hold) src_valid[0] = (ai < 5) && ($urandom_range(0, 2) != 0);
            src_tag[0]   = TAG_W'(ai + 18);
            src_data[0]  = DATA_W'(32'hC000_0000 + ai);
            src_valid[2] = (li < 5);
            src_tag[2]   = TAG_W'(li + 26);
            src_data[2]  = DATA_W'(32'hD000_0000 + li);
            acc_a = src_valid[0] && rdy[0];
            acc_l = src_valid[2] && rdy[2];
            if (acc_a) acc_cnt++;
            @(negedge clk_i);
            cyc++;
            if (cdb_en_o === 1'b1) begin
                if (cdb_src_o === 2'd0) rx_a.push_back(cdb_tag_o);
                else if (cdb_src_o === 2'd2) rx_l.push_back(cdb_tag_o);
            end
            checks++;
            if (acc_cnt - rx_a.size() > FIFO_DEPTH || rdy[0] !== (msize(0) != FIFO_DEPTH)) begin
                failures++;
                $display("[TB] FAIL wrap_occupancy: cycle %0d outstanding=%0d ready=%0b, want <=%0d ready=%0b",
                         cyc, acc_cnt - rx_a.size(), rdy[0], FIFO_DEPTH, msize(0) != FIFO_DEPTH);
            end
        end
        clear_inputs();
        checks++;
        if (rx_a.size() != 5 || rx_l.size() != 5) begin
            failures++;
            $display("[TB] FAIL wrap_count: got alu=%0d lsu=%0d broadcasts, want 5 and 5",
                     rx_a.size(), rx_l.size());
        end
        for (int i = 0; i < rx_a.size(); i++) begin
            checks++;
            if (rx_a[i] !== TAG_W'(18 + i)) begin
                failures++;
                $display("[TB] FAIL wrap_alu_order[%0d]: got tag %0d, want %0d", i, rx_a[i], 18 + i);
            end
        end
        for (int i = 0; i < rx_l.size(); i++) begin
            checks++;
            if (rx_l[i] !== TAG_W'(26 + i)) begin
                failures++;
                $display("[TB] FAIL wrap_lsu_order[%0d]: got tag %0d, want %0d", i, rx_l[i], 26 + i);
            end
        end
    endtask

    task automatic test_random();
        bit acc [3];
        do_flush();
        for (int k = 0; k < 3; k++) acc[k] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) src_valid[k] = 1'b0;
                if (!src_valid[k] && $urandom_range(0, 99) < 55) begin
                    src_valid[k] = 1'b1;
                    src_tag[k]   = TAG_W'($urandom);
                    src_data[k]  = DATA_W'($urandom);
                end
            end
            flush_i = ($urandom_range(0, 99) < 3);
            for (int k = 0; k < 3; k++) acc[k] = src_valid[k] && rdy[k];
            @(negedge clk_i);
            checks++;
            if ({cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o} !== {m_en, m_tag, m_data, m_src}) begin
                failures++;
                $display("[TB] FAIL random_cdb: cycle %0d got en=%0b tag=%0d data=%h src=%0d, want en=%0b tag=%0d data=%h src=%0d",
                         cyc, cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o, m_en, m_tag, m_data, m_src);
            end
            checks++;
            if (rdy !== exp_rdy()) begin
                failures++;
                $display("[TB] FAIL random_ready: cycle %0d got %b, want %b", cyc, rdy, exp_rdy());
            end
        end
        flush_i = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] cdb_arbiter bench start");
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_flush();
        test_wraparound();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
